// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension path: mode encoding,
// default widths and the extension function used by the pipe and the decoder.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_t;

  localparam int IMM_IN_W  = 16;
  localparam int IMM_OUT_W = 32;
  localparam int IMM_SHAMT = 2;
  localparam int IMM_TAG_W = 5;
  // Widest output the generic extender supports.
  localparam int IMM_MAX_W = 64;

  // Width-generic extender: imm holds an in_w-bit immediate in its low bits,
  // the result occupies the low out_w bits. Call with constant widths so the
  // loop collapses to pure wiring.
  function automatic logic [IMM_MAX_W-1:0] imm_extend_w(
    input logic [IMM_MAX_W-1:0] imm,
    input imm_mode_t            mode,
    input int                   in_w,
    input int                   out_w,
    input int                   shamt
  );
    logic [IMM_MAX_W-1:0] r;
    logic                 sgn;
    r   = '0;
    sgn = imm[in_w-1];
    for (int i = 0; i < IMM_MAX_W; i++) begin
      case (mode)
        MODE_SIGN:   if (i < out_w) r[i] = (i < in_w) ? imm[i] : sgn;
        MODE_ZERO:   if (i < in_w) r[i] = imm[i];
        MODE_UPPER:  if (i >= out_w - in_w && i < out_w) r[i] = imm[i-(out_w-in_w)];
        MODE_BRANCH: if (i >= shamt && i < out_w) r[i] = (i - shamt < in_w) ? imm[i-shamt] : sgn;
        default:     ;
      endcase
    end
    return r;
  endfunction

  // Extension at the default decoder widths.
  function automatic logic [IMM_OUT_W-1:0] imm_extend(
    input logic [IMM_IN_W-1:0] imm,
    input imm_mode_t           mode
  );
    return IMM_OUT_W'(imm_extend_w(IMM_MAX_W'(imm), mode, IMM_IN_W, IMM_OUT_W, IMM_SHAMT));
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode (master) and the extension pipe (slave),
// carrying both the request side and the response side.
interface imm_extend_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W,
  parameter int TAG_W = IMM_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  imm_mode_t        in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_ext_skid.sv
// Two-entry registered pipeline stage: main output register M plus skid
// register S. in_ready comes straight from a flop so no combinational path
// runs from downstream ready back to upstream.
module imm_ext_skid #(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  logic             r_m_valid;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_m_data;
  logic [WIDTH-1:0] r_s_data;
  logic             w_acc;
  logic             w_drn;

  assign w_acc = i_valid & ~r_s_valid;
  assign w_drn = r_m_valid & i_ready;

  // M/S update: S always refills M first so ordering stays FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      // NOTE: the payload registers are reset too because out_data must read 0 while rst is high.
      r_m_data  <= '0;
      r_s_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      if (!r_m_valid || w_drn) begin
        if (r_s_valid) begin
          r_m_valid <= 1'b1;
          r_m_data  <= r_s_data;
          r_s_valid <= w_acc;
          if (w_acc) r_s_data <= i_data;
        end else begin
          r_m_valid <= w_acc;
          if (w_acc) r_m_data <= i_data;
        end
      end else if (w_acc) begin
        r_s_valid <= 1'b1;
        r_s_data  <= i_data;
      end
    end
  end

  assign o_ready = ~r_s_valid;
  assign o_valid = r_m_valid;
  assign o_data  = r_m_data;

  a_ready_is_skid_empty: assert property (@(posedge clk) disable iff (rst)
    o_ready == !r_s_valid);
  a_stable_under_stall: assert property (@(posedge clk) disable iff (rst)
    (r_m_valid && !i_ready) |=> (r_m_valid && $stable(r_m_data)));
  a_occupancy_max_two: assert property (@(posedge clk) disable iff (rst)
    r_s_valid |-> r_m_valid);
endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: extension is combinational on the request
// side, then tag and result travel together through the skid stage.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W,
  parameter int SHAMT = IMM_SHAMT,
  parameter int TAG_W = IMM_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  imm_extend_pipe_if.slave   bus
);
  if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must satisfy 1 <= IN_W < OUT_W");
  end
  if (SHAMT < 0 || SHAMT >= OUT_W) begin : g_bad_shamt
    $error("imm_extend_pipe: SHAMT must satisfy 0 <= SHAMT < OUT_W");
  end
  if (OUT_W > IMM_MAX_W) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W exceeds the generic extender width");
  end

  logic [OUT_W-1:0]       w_ext;
  logic [OUT_W+TAG_W-1:0] w_pack_out;

  assign w_ext = OUT_W'(imm_extend_w(IMM_MAX_W'(bus.in_imm), bus.in_mode, IN_W, OUT_W, SHAMT));

  imm_ext_skid #(
    .WIDTH (OUT_W + TAG_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  ({bus.in_tag, w_ext}),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_pack_out)
  );

  assign bus.out_data = w_pack_out[OUT_W-1:0];
  assign bus.out_tag  = w_pack_out[OUT_W +: TAG_W];
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: the driver queues the expected
// response on every accepted request, the monitor pops on every transfer.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  imm_extend_pipe_if bus ();

  imm_extend_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  exp_t        sb[$];
  logic        stalled = 1'b0;
  logic [36:0] held;
  bit          done_stream;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Bench reference using signed arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input imm_mode_t mode);
    logic signed [31:0] s;
    s = $signed(imm);
    case (mode)
      MODE_SIGN:  return s;
      MODE_ZERO:  return {16'h0000, imm};
      MODE_UPPER: return {imm, 16'h0000};
      default:    return s * 4;
    endcase
  endfunction

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request until accepted; returns at posedge+1 after transfer.
  task automatic send(input logic [15:0] imm, input imm_mode_t mode, input logic [4:0] tag,
                      input logic [31:0] want, input bit chk_lat);
    bit   done = 1'b0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.data = want;
        e.tag  = tag;
        sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d in_ready=%0b want=1", tag, bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (chk_lat) begin
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("lat_data", 64'(bus.out_data), 64'(want));
        check("lat_tag", 64'(bus.out_tag), 64'(tag));
      end
    end
  endtask

  // Monitor: compare on every transfer, check stability across stalls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_payload", 64'({bus.out_tag, bus.out_data}), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output tag=%0d data=%h want=none", bus.out_tag, bus.out_data);
        end else begin
          e = sb.pop_front();
          check("sb_data", 64'(bus.out_data), 64'(e.data));
          check("sb_tag", 64'(bus.out_tag), 64'(e.tag));
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = {bus.out_tag, bus.out_data};
    end
  end

  initial begin
    int          n_before;
    logic [15:0] r_imm;
    imm_mode_t   r_mode;
    logic [4:0]  r_tag;

    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = MODE_SIGN;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Mode sweep, one-cycle latency
    bus.out_ready = 1'b1;
    send(16'h8001, MODE_SIGN,   5'd10, 32'hFFFF8001, 1'b1);
    send(16'h8001, MODE_ZERO,   5'd11, 32'h00008001, 1'b1);
    send(16'h1234, MODE_UPPER,  5'd12, 32'h12340000, 1'b1);
    send(16'hFFFF, MODE_BRANCH, 5'd13, 32'hFFFFFFFC, 1'b1);
    send(16'h7FFF, MODE_BRANCH, 5'd14, 32'h0001FFFC, 1'b1);
    idle(2);

    // Back-pressure: two accepted, third waits
    bus.out_ready = 1'b0;
    send(16'h0001, MODE_SIGN, 5'd1, 32'h00000001, 1'b0);
    send(16'hFFFF, MODE_ZERO, 5'd2, 32'h0000FFFF, 1'b0);
    check("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
    check("bp_head_tag", 64'(bus.out_tag), 64'd1);
    fork
      send(16'hABCD, MODE_UPPER, 5'd3, 32'hABCD0000, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_tag3_waits", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
      end
    join
    idle(3);

    // Accept and drain together at occupancy 1
    n_before = n_out;
    send(16'hFFF0, MODE_BRANCH, 5'd20, 32'hFFFFFFC0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      send(16'hFFF0 + 16'(i), MODE_BRANCH, 5'(20 + i), 32'hFFFFFFC0 + 32'(4 * i), 1'b1);
      check("occ1_in_ready", 64'(bus.in_ready), 64'd1);
    end
    idle(2);
    check("occ1_outputs", 64'(n_out - n_before), 64'd11);

    // Async reset at occupancy 2
    bus.out_ready = 1'b0;
    send(16'h1111, MODE_SIGN, 5'd7, 32'h00001111, 1'b0);
    send(16'h2222, MODE_ZERO, 5'd8, 32'h00002222, 1'b0);
    check("rst2_pre_full", 64'(bus.in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst2_out_data", 64'(bus.out_data), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_post_empty", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    send(16'h8000, MODE_BRANCH, 5'd9, 32'hFFFE0000, 1'b1);
    idle(2);

    // Streaming with random back-pressure
    done_stream = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          r_imm  = 16'($urandom);
          r_mode = imm_mode_t'($urandom_range(0, 3));
          r_tag  = 5'($urandom);
          send(r_imm, r_mode, r_tag, ref_ext(r_imm, r_mode), 1'b0);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        done_stream = 1'b1;
      end
      begin
        while (!done_stream) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    for (int k = 0; k < 500 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    idle(2);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
